// File: rtl/xif_coproc_issue_responder.sv
// rtl/xif_coproc_issue_responder.sv - CV-X-IF issue responder with in-order issue FIFO
// Decodes offered instructions, answers accept/writeback, queues accepted ones for execute.
module xif_coproc_issue_responder #(
  parameter int         XLEN       = 32,
  parameter int         X_NUM_RS   = 3,
  parameter int         X_ID_WIDTH = 4,
  parameter int         DEPTH      = 4,
  parameter logic [6:0] OPCODE     = 7'h0B,
  parameter int         CNT_W      = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     issue_valid_i,
  output logic                     issue_ready_o,
  input  logic [31:0]              issue_instr_i,
  input  logic [X_ID_WIDTH-1:0]    issue_id_i,
  input  logic [X_NUM_RS*XLEN-1:0] issue_rs_i,
  input  logic [X_NUM_RS-1:0]      issue_rs_valid_i,
  output logic                     issue_accept_o,
  output logic                     issue_writeback_o,
  input  logic                     flush_i,
  output logic                     exe_valid_o,
  input  logic                     exe_ready_i,
  output logic [31:0]              exe_instr_o,
  output logic [X_ID_WIDTH-1:0]    exe_id_o,
  output logic [X_NUM_RS*XLEN-1:0] exe_rs_o,
  output logic [CNT_W-1:0]         acc_cnt_o,
  output logic [CNT_W-1:0]         rej_cnt_o
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int RSW = X_NUM_RS * XLEN;

  logic [X_ID_WIDTH-1:0] id_mem    [DEPTH];
  logic [31:0]           instr_mem [DEPTH];
  logic [RSW-1:0]        rs_mem    [DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [CW-1:0]         count;
  logic [2:0]            rsv;
  logic [RSW-1:0]        push_rs;
  logic                  match, need3, rs_ok, push, pop, reject;

  always_comb begin
    rsv    = 3'(issue_rs_valid_i);
    match  = issue_instr_i[6:0] == OPCODE;
    need3  = match && (issue_instr_i[14:12] == 3'b111) && (X_NUM_RS == 3);
    rs_ok  = rsv[0] && rsv[1] && (!need3 || rsv[2]);
    // Ready never depends on exe_ready_i: a full FIFO stalls a match even while popping.
    issue_ready_o     = issue_valid_i && !flush_i && (!match || (rs_ok && count < CW'(DEPTH)));
    issue_accept_o    = match;
    issue_writeback_o = match && (issue_instr_i[11:7] != 5'd0);
    push   = issue_ready_o && match;
    reject = issue_ready_o && !match;
    pop    = exe_valid_o && exe_ready_i;
    push_rs = issue_rs_i;
    for (int i = 0; i < X_NUM_RS; i++) begin
      if (i == 2 && !need3) push_rs[i*XLEN +: XLEN] = '0;
    end
  end

  assign exe_valid_o = count != '0;
  assign exe_instr_o = instr_mem[rptr];
  assign exe_id_o    = id_mem[rptr];
  assign exe_rs_o    = rs_mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      acc_cnt_o <= '0;
      rej_cnt_o <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_mem[i]    <= '0;
        instr_mem[i] <= '0;
        rs_mem[i]    <= '0;
      end
    end else begin
      if (flush_i) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          id_mem[wptr]    <= issue_id_i;
          instr_mem[wptr] <= issue_instr_i;
          rs_mem[wptr]    <= push_rs;
          wptr            <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
      if (push && acc_cnt_o != '1)   acc_cnt_o <= acc_cnt_o + 1'b1;
      if (reject && rej_cnt_o != '1) rej_cnt_o <= rej_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_xif_coproc_issue_responder.sv
// tb/tb_xif_coproc_issue_responder.sv - randomized bench with queue-based reference model
module tb_xif_coproc_issue_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, flush, exe_ready;
  logic [31:0] instr;
  logic [3:0]  id;
  logic [95:0] rs;
  logic [2:0]  rsv;
  logic        ready, accept, wb, exe_valid;
  logic [31:0] exe_instr;
  logic [3:0]  exe_id;
  logic [95:0] exe_rs;
  logic [15:0] acc_cnt, rej_cnt;

  xif_coproc_issue_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(valid), .issue_ready_o(ready), .issue_instr_i(instr),
    .issue_id_i(id), .issue_rs_i(rs), .issue_rs_valid_i(rsv),
    .issue_accept_o(accept), .issue_writeback_o(wb), .flush_i(flush),
    .exe_valid_o(exe_valid), .exe_ready_i(exe_ready), .exe_instr_o(exe_instr),
    .exe_id_o(exe_id), .exe_rs_o(exe_rs), .acc_cnt_o(acc_cnt), .rej_cnt_o(rej_cnt)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] instr;
    logic [95:0] rs;
  } ent_t;

  ent_t q[$];
  int   acc_m, rej_m;
  int   checks, errors;
  bit   held;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check combinational answers and head against the model, then take one clock edge.
  task automatic cycle();
    bit m, n3, ok, rdy;
    logic [2:0] req;
    ent_t e;
    #1;
    m   = instr[6:0] == 7'h0B;
    n3  = m && instr[14:12] == 3'b111;
    req = n3 ? 3'b111 : 3'b011;
    ok  = (rsv & req) == req;
    rdy = valid && !flush && (!m || (ok && q.size() < 4));
    check("ready", ready, rdy);
    if (rdy) begin
      check("accept", accept, m);
      check("writeback", wb, m && instr[11:7] != 5'd0);
    end
    check("exe_valid", exe_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("exe_instr", exe_instr, q[0].instr);
      check("exe_id", exe_id, q[0].id);
      check("exe_rs", exe_rs, q[0].rs);
    end
    check("acc_cnt", acc_cnt, acc_m);
    check("rej_cnt", rej_cnt, rej_m);
    if (flush) q.delete();
    else begin
      if (q.size() != 0 && exe_ready) e = q.pop_front();
      if (rdy && m) begin
        e.id    = id;
        e.instr = instr;
        e.rs    = n3 ? rs : {32'h0, rs[63:0]};
        q.push_back(e);
      end
    end
    if (rdy) begin
      if (m) acc_m++;
      else rej_m++;
    end
    held = valid && !rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [31:0] ins, logic [3:0] i, logic [2:0] v);
    valid = 1'b1; instr = ins; id = i; rsv = v;
    rs = {$urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    valid = 1'b0; flush = 1'b0; exe_ready = 1'b1;
    repeat (6) cycle();
  endtask

  initial begin
    checks = 0; errors = 0; acc_m = 0; rej_m = 0; held = 1'b0;
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; exe_ready = 1'b0;
    instr = '0; id = '0; rs = '0; rsv = '0;
    #3;
    check("rst_ready", ready, 1'b0);
    check("rst_exe_valid", exe_valid, 1'b0);
    check("rst_exe_instr", exe_instr, 32'h0);
    check("rst_acc", acc_cnt, 16'h0);
    check("rst_rej", rej_cnt, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Matching offer with rd=2, then head appears next cycle
    offer(32'h0000_010B, 4'd1, 3'b011);
    cycle();
    valid = 1'b0;
    #1;
    check("t1_exe_valid", exe_valid, 1'b1);
    check("t1_exe_instr", exe_instr, 32'h0000_010B);
    cycle();

    // Opcode mismatch is rejected at once
    offer(32'h0000_0033, 4'd2, 3'b000);
    cycle();
    valid = 1'b0;
    check("t2_rej", rej_cnt, 16'd1);
    drain();

    // Three-operand instruction waits for rs[2]
    offer(32'h0000_710B, 4'd3, 3'b011);
    repeat (3) cycle();
    rsv = 3'b111;
    cycle();
    drain();

    // Fill to full, fifth offer stalls despite a same-cycle pop
    exe_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(32'h0000_008B, 4'(i), 3'b011);
      cycle();
    end
    offer(32'h0000_008B, 4'd4, 3'b011);
    exe_ready = 1'b1;
    #1;
    check("t4_full_ready", ready, 1'b0);
    cycle();
    cycle();
    drain();

    // Flush with a valid match in the same cycle
    exe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h0000_030B, 4'(i), 3'b011);
      cycle();
    end
    offer(32'h0000_030B, 4'd7, 3'b011);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    valid = 1'b0;
    check("t5_exe_valid", exe_valid, 1'b0);
    check("t5_acc", acc_cnt, 16'd10);
    cycle();

    // Randomized traffic; held instructions stay stable while rs_valid may rise
    for (int n = 0; n < 400; n++) begin
      if (held) begin
        rsv = rsv | 3'($urandom);
      end else begin
        valid = $urandom_range(0, 3) != 0;
        instr = $urandom;
        if ($urandom_range(0, 9) < 6) instr[6:0] = 7'h0B;
        id  = 4'($urandom);
        rs  = {$urandom, $urandom, $urandom};
        rsv = 3'($urandom);
      end
      flush     = $urandom_range(0, 19) == 0;
      exe_ready = $urandom_range(0, 2) != 0;
      cycle();
    end

    // Asynchronous reset between edges
    exe_ready = 1'b0;
    offer(32'h0000_010B, 4'd9, 3'b011);
    flush = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_exe_valid", exe_valid, 1'b0);
    check("t6_acc", acc_cnt, 16'h0);
    check("t6_rej", rej_cnt, 16'h0);
    q.delete();
    acc_m = 0;
    rej_m = 0;
    valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    offer(32'h0000_010B, 4'd5, 3'b011);
    cycle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
